// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
//   - Register offsets relative to BASE_ADDR (TXDATA, STATUS).
//   - STATUS layout as a packed struct. The first field listed is bit 3.
//   - Transmit FSM state encodings (2-bit).
//   - Helper that rounds CLK_HZ/BAUD to the nearest whole clock count per bit.
package mmio_uart_tx_pkg;

  localparam logic [31:0] TXDATA_OFFSET = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFFSET = 32'h0000_0004;

  // STATUS write: setting this bit clears the sticky overflow flag.
  localparam int STAT_OVF_BIT = 3;

  // STATUS read value, bits 3..0.
  typedef struct packed {
    logic overflow;
    logic busy;
    logic fifo_empty;
    logic fifo_full;
  } status_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Round to the nearest integer so that the baud error stays symmetric.
  function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous FIFO with a combinational head output.
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   push, wdata   : enqueue request and data. Accepted when not full, or when a pop
//                   happens in the same cycle.
//   pop           : dequeue request. Ignored when empty.
//   rdata         : current head entry, valid while !empty
//   full, empty   : occupancy flags, derived from count
//   count         : number of stored entries, 0..DEPTH
module mmio_uart_tx_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  // A push into a full FIFO succeeds only when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments, so that every register
  // samples its inputs from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are log2(DEPTH) bits wide and wrap on their own.
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is left out of reset on purpose. An entry is never read
  // before it has been written, and leaving out the reset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter attached to the core's data-memory store port.
// Ports:
//   clk       : system clock. All state changes on the rising edge.
//   rst       : synchronous, active-high reset
//   w_en      : store strobe, sampled on every edge
//   addr      : store/load byte address
//   wdata     : store data. [7:0] is the TXDATA byte. [3] clears overflow in STATUS.
//   rdata     : combinational load data. STATUS when addr == BASE_ADDR+4, otherwise 0.
//   tx        : registered serial line, idles high
//   busy      : a frame is in flight or bytes are still queued
//   overflow  : sticky flag, set when a TXDATA store was dropped because the FIFO was full
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter int          CLK_HZ     = 100_000_000,
  parameter int          BAUD       = 115200,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        w_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        busy,
  output logic        overflow
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_HZ, BAUD);
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam int FIFO_CNT_W   = $clog2(FIFO_DEPTH) + 1;

  logic                  sel_txdata;
  logic                  sel_status;
  logic                  push_req;
  logic                  clr_ovf;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [7:0]            fifo_head;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic                  unused_wdata_hi;

  tx_state_e             state;
  logic [CNT_W-1:0]      baud_cnt;
  logic [2:0]            bit_idx;
  logic [7:0]            shift;
  logic                  bit_done;
  status_t               status;

  // Address decode
  assign sel_txdata = (addr == BASE_ADDR + TXDATA_OFFSET);
  assign sel_status = (addr == BASE_ADDR + STATUS_OFFSET);
  assign push_req   = w_en && sel_txdata;
  assign clr_ovf    = w_en && sel_status && wdata[STAT_OVF_BIT];

  // Only the low byte and the overflow-clear bit of a store are meaningful.
  assign unused_wdata_hi = ^wdata[31:8];

  assign bit_done = (baud_cnt == CNT_LAST);

  // The FSM looks at the FIFO state from the previous edge. A byte written into an
  // empty FIFO is therefore popped one clock after it lands, never in the same cycle.
  assign fifo_pop = !fifo_empty &&
                    ((state == ST_IDLE) || (state == ST_STOP && bit_done));

  mmio_uart_tx_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .wdata (wdata[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Decoded from registers only, so busy never depends on the incoming bus.
  assign busy = (state != ST_IDLE) || (fifo_count != '0);

  // A dropped store needs the full count from the previous edge and no pop in this
  // cycle. A store that arrives while the head leaves still fits in the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (push_req && fifo_full && !fifo_pop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      // The line follows the state one clock later. The FSM pops at edge N+1 and
      // the start bit appears from edge N+2. Each bit keeps its full length.
      case (state)
        ST_START: tx <= 1'b0;
        ST_DATA:  tx <= shift[0];
        default:  tx <= 1'b1;
      endcase

      case (state)
        ST_IDLE: begin
          baud_cnt <= '0;
          if (fifo_pop) begin
            shift <= fifo_head;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            shift    <= {1'b0, shift[7:1]};
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            // Chain straight into the next start bit, so queued frames have no idle gap.
            if (fifo_pop) begin
              shift <= fifo_head;
              state <= ST_START;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign status = {overflow, busy, fifo_empty, fifo_full};

  // NOTE: rdata gets a default before the decode, so every path assigns it and no
  // latch is inferred.
  always_comb begin
    rdata = '0;
    if (sel_status) rdata = {28'b0, status};
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Testbench for mmio_uart_tx.
// Two instances share one clock:
//   dut_a : default parameters, 868 clocks per bit.
//   dut_b : CLK_HZ=1000 and BAUD=100, which gives 10 clocks per bit.
// A serial monitor decodes frames from the selected instance. It compares each
// frame against bytes that the tests pushed into a scoreboard queue when they
// issued the stores.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam int          CPB_A = 868;
  localparam int          CPB_B = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, w_en_a, tx_a, busy_a, overflow_a;
  logic [31:0] addr_a, wdata_a, rdata_a;
  logic        rst_b, w_en_b, tx_b, busy_b, overflow_b;
  logic [31:0] addr_b, wdata_b, rdata_b;

  mmio_uart_tx dut_a (
    .clk      (clk),
    .rst      (rst_a),
    .w_en     (w_en_a),
    .addr     (addr_a),
    .wdata    (wdata_a),
    .rdata    (rdata_a),
    .tx       (tx_a),
    .busy     (busy_a),
    .overflow (overflow_a)
  );

  mmio_uart_tx #(
    .CLK_HZ (1000),
    .BAUD   (100)
  ) dut_b (
    .clk      (clk),
    .rst      (rst_b),
    .w_en     (w_en_b),
    .addr     (addr_b),
    .wdata    (wdata_b),
    .rdata    (rdata_b),
    .tx       (tx_b),
    .busy     (busy_b),
    .overflow (overflow_b)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] sb[$];
  int         frame_starts[$];

  logic       mon_en;
  logic       mon_sel;
  logic       mon_tx;
  logic       busy_m;
  int         mon_cpb;
  logic [9:0] mon_bits;
  logic       mon_abort;
  logic [7:0] mon_exp;

  assign mon_tx = mon_sel ? tx_b : tx_a;
  assign busy_m = mon_sel ? busy_b : busy_a;

  // Serial monitor. It takes the first low sample as the start of a frame and then
  // samples each bit in its middle. A frame is abandoned if the monitor is disabled
  // while the frame is still in progress.
  initial begin : uart_monitor
    forever begin
      @(negedge clk);
      if (mon_en && mon_tx === 1'b0) begin
        mon_cpb = mon_sel ? CPB_B : CPB_A;
        frame_starts.push_back(cyc);
        mon_abort = 1'b0;
        for (int k = 0; k < 10; k++) begin
          if (k == 0) repeat (mon_cpb / 2) @(negedge clk);
          else        repeat (mon_cpb) @(negedge clk);
          if (!mon_en) begin
            mon_abort = 1'b1;
            break;
          end
          mon_bits[k] = mon_tx;
        end
        if (!mon_abort) begin
          checks++;
          if (mon_bits[0] !== 1'b0 || mon_bits[9] !== 1'b1) begin
            fails++;
            $display("FAIL frame_bits: start=%b stop=%b, required start=0 stop=1",
                     mon_bits[0], mon_bits[9]);
          end
          checks++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_frame: got byte 0x%02h, scoreboard empty", mon_bits[8:1]);
          end else begin
            mon_exp = sb.pop_front();
            if (mon_bits[8:1] !== mon_exp) begin
              fails++;
              $display("FAIL frame_data: got 0x%02h, required 0x%02h", mon_bits[8:1], mon_exp);
            end
          end
        end
      end
    end
  end

  task automatic write_a(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    w_en_a = 1'b1; addr_a = a; wdata_a = d;
  endtask

  task automatic idle_a();
    @(negedge clk);
    w_en_a = 1'b0; addr_a = BASE + 32'h4; wdata_a = '0;
  endtask

  task automatic write_b(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    w_en_b = 1'b1; addr_b = a; wdata_b = d;
  endtask

  task automatic idle_b();
    @(negedge clk);
    w_en_b = 1'b0; addr_b = BASE + 32'h4; wdata_b = '0;
  endtask

  task automatic wait_not_busy(input int max_cycles, input string what);
    int n;
    n = 0;
    while (busy_m !== 1'b0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy_m !== 1'b0) begin
      fails++;
      $display("FAIL %s: busy=%b after %0d cycles, required 0", what, busy_m, n);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (3) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    addr_a = BASE + 32'h4; addr_b = BASE + 32'h4;
    @(negedge clk);
    #1;
    checks++; if (tx_a !== 1'b1)      begin fails++; $display("FAIL reset_tx_a: %b, required 1", tx_a); end
    checks++; if (busy_a !== 1'b0)    begin fails++; $display("FAIL reset_busy_a: %b, required 0", busy_a); end
    checks++; if (overflow_a !== 1'b0) begin fails++; $display("FAIL reset_ovf_a: %b, required 0", overflow_a); end
    checks++; if (rdata_a !== 32'h2)  begin fails++; $display("FAIL reset_status_a: 0x%0h, required 0x2", rdata_a); end
    checks++; if (tx_b !== 1'b1)      begin fails++; $display("FAIL reset_tx_b: %b, required 1", tx_b); end
    checks++; if (rdata_b !== 32'h2)  begin fails++; $display("FAIL reset_status_b: 0x%0h, required 0x2", rdata_b); end
  endtask

  // Store 0x55 -> tx stays high at edge N+1, start bit from edge N+2, full frame, then not busy.
  task automatic test_single_frame();
    mon_sel = 1'b0;
    sb.push_back(8'h55);
    write_a(BASE, 32'h55);
    idle_a();
    @(negedge clk);
    checks++; if (tx_a !== 1'b1) begin fails++; $display("FAIL latency_n1: tx=%b, required 1", tx_a); end
    @(negedge clk);
    checks++; if (tx_a !== 1'b0) begin fails++; $display("FAIL latency_n2: tx=%b, required 0", tx_a); end
    repeat (9 * CPB_A + CPB_A / 2) @(negedge clk);
    checks++; if (busy_a !== 1'b1) begin fails++; $display("FAIL busy_mid_stop: %b, required 1", busy_a); end
    repeat (CPB_A - CPB_A / 2) @(negedge clk);
    checks++; if (busy_a !== 1'b0) begin fails++; $display("FAIL busy_after_stop: %b, required 0", busy_a); end
    checks++; if (sb.size() != 0) begin fails++; $display("FAIL single_pending: %0d left, required 0", sb.size()); end
    repeat (3) @(negedge clk);
  endtask

  // Three stores on consecutive cycles -> contiguous frames exactly 10 bit times apart.
  task automatic test_back_to_back();
    mon_sel = 1'b0;
    frame_starts.delete();
    for (int i = 0; i < 3; i++) begin
      sb.push_back(8'h41 + 8'(i));
      write_a(BASE, 32'h41 + i);
    end
    idle_a();
    wait_not_busy(31 * CPB_A, "b2b_done");
    checks++;
    if (frame_starts.size() != 3) begin
      fails++; $display("FAIL b2b_frames: %0d frames, required 3", frame_starts.size());
    end
    if (frame_starts.size() >= 3) begin
      checks++;
      if (frame_starts[1] - frame_starts[0] != 10 * CPB_A) begin
        fails++; $display("FAIL b2b_gap1: %0d clocks, required %0d", frame_starts[1] - frame_starts[0], 10 * CPB_A);
      end
      checks++;
      if (frame_starts[2] - frame_starts[1] != 10 * CPB_A) begin
        fails++; $display("FAIL b2b_gap2: %0d clocks, required %0d", frame_starts[2] - frame_starts[1], 10 * CPB_A);
      end
    end
    checks++; if (sb.size() != 0) begin fails++; $display("FAIL b2b_pending: %0d left, required 0", sb.size()); end
  endtask

  // Stores to unmapped addresses do nothing. Reads decode only STATUS.
  task automatic test_decode();
    int lows;
    int busies;
    mon_sel = 1'b0;
    write_a(BASE + 32'h8, 32'h55);
    write_a(32'h0, 32'hAA);
    idle_a();
    lows = 0; busies = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx_a !== 1'b1) lows++;
      if (busy_a !== 1'b0) busies++;
    end
    checks++; if (lows != 0)   begin fails++; $display("FAIL decode_tx: %0d low cycles, required 0", lows); end
    checks++; if (busies != 0) begin fails++; $display("FAIL decode_busy: %0d busy cycles, required 0", busies); end
    addr_a = BASE + 32'h8; #1;
    checks++; if (rdata_a !== 32'h0) begin fails++; $display("FAIL rd_base8: 0x%0h, required 0x0", rdata_a); end
    addr_a = 32'h0; #1;
    checks++; if (rdata_a !== 32'h0) begin fails++; $display("FAIL rd_zero: 0x%0h, required 0x0", rdata_a); end
    addr_a = BASE; #1;
    checks++; if (rdata_a !== 32'h0) begin fails++; $display("FAIL rd_txdata: 0x%0h, required 0x0", rdata_a); end
    addr_a = BASE + 32'h4; #1;
    checks++; if (rdata_a !== 32'h2) begin fails++; $display("FAIL rd_status_idle: 0x%0h, required 0x2", rdata_a); end
  endtask

  // Ten stores: 1 in shifter + 8 queued are sent, the 10th is dropped and sets overflow.
  task automatic test_overflow();
    mon_sel = 1'b1;
    frame_starts.delete();
    for (int i = 0; i < 10; i++) begin
      if (i < 9) sb.push_back(8'h10 + 8'(i));
      write_b(BASE, 32'h10 + i);
    end
    idle_b();
    #1;
    checks++; if (rdata_b !== 32'hD) begin fails++; $display("FAIL ovf_status: 0x%0h, required 0xD", rdata_b); end
    checks++; if (overflow_b !== 1'b1) begin fails++; $display("FAIL ovf_flag: %b, required 1", overflow_b); end
    w_en_b = 1'b1; wdata_b = 32'h8;
    @(negedge clk);
    w_en_b = 1'b0; wdata_b = '0;
    #1;
    checks++; if (rdata_b !== 32'h5) begin fails++; $display("FAIL ovf_clear: 0x%0h, required 0x5", rdata_b); end
    wait_not_busy(9 * 10 * CPB_B + 200, "ovf_done");
    checks++;
    if (frame_starts.size() != 9) begin
      fails++; $display("FAIL ovf_frames: %0d frames, required 9", frame_starts.size());
    end
    if (frame_starts.size() >= 9) begin
      checks++;
      if (frame_starts[8] - frame_starts[0] != 80 * CPB_B) begin
        fails++; $display("FAIL ovf_span: %0d clocks, required %0d", frame_starts[8] - frame_starts[0], 80 * CPB_B);
      end
    end
    checks++; if (sb.size() != 0) begin fails++; $display("FAIL ovf_pending: %0d left, required 0", sb.size()); end
  endtask

  // Reset in the middle of data bit 3 of the first of four queued bytes.
  task automatic test_mid_frame_reset();
    int lows;
    mon_sel = 1'b1;
    mon_en  = 1'b0;
    write_b(BASE, 32'hF7);
    write_b(BASE, 32'h11);
    write_b(BASE, 32'h22);
    write_b(BASE, 32'h33);
    idle_b();
    // Now one clock into the start bit. Data bit 3 covers bit-times 40..49 from its start.
    repeat (44) @(negedge clk);
    checks++; if (tx_b !== 1'b0) begin fails++; $display("FAIL rst_bit3: tx=%b, required 0 (bit 3 of 0xF7)", tx_b); end
    rst_b = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (tx_b !== 1'b1) begin fails++; $display("FAIL rst_tx: %b, required 1", tx_b); end
    checks++; if (rdata_b !== 32'h2) begin fails++; $display("FAIL rst_status: 0x%0h, required 0x2", rdata_b); end
    rst_b = 1'b0;
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx_b !== 1'b1) lows++;
    end
    checks++; if (lows != 0) begin fails++; $display("FAIL rst_no_frames: %0d low cycles, required 0", lows); end
    checks++; if (busy_b !== 1'b0) begin fails++; $display("FAIL rst_busy: %b, required 0", busy_b); end
    mon_en = 1'b1;
  endtask

  // 10 clocks per bit: 0xFF -> exactly 10 low clocks (start) then 90 high.
  task automatic test_fast_baud();
    int n;
    int lows;
    int highs;
    mon_sel = 1'b1;
    sb.push_back(8'hFF);
    write_b(BASE, 32'hFF);
    idle_b();
    n = 0;
    while (tx_b !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    lows = 0;
    while (tx_b === 1'b0 && lows < 50) begin
      lows++;
      @(negedge clk);
    end
    highs = 0;
    repeat (90) begin
      if (tx_b === 1'b1) highs++;
      @(negedge clk);
    end
    checks++; if (lows != 10)  begin fails++; $display("FAIL fast_low: %0d clocks, required 10", lows); end
    checks++; if (highs != 90) begin fails++; $display("FAIL fast_high: %0d clocks, required 90", highs); end
    wait_not_busy(50, "fast_done");
    checks++; if (sb.size() != 0) begin fails++; $display("FAIL fast_pending: %0d left, required 0", sb.size()); end
  endtask

  initial begin
    rst_a = 1'b1; w_en_a = 1'b0; addr_a = '0; wdata_a = '0;
    rst_b = 1'b1; w_en_b = 1'b0; addr_b = '0; wdata_b = '0;
    mon_en = 1'b1; mon_sel = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_decode();
    test_overflow();
    test_mid_frame_reset();
    test_fast_baud();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
